// File: rtl/stream_rr_arbiter_pkg.sv
// Shared arbiter definitions: the CLOG2 sizing macro and a mod-N index helper.
// Kept generic so other arbiters in the codebase can import the same helpers.
`ifndef STREAM_ARB_DEFS
`define STREAM_ARB_DEFS
`define CLOG2(x) $clog2(x)
`endif

package stream_rr_arbiter_pkg;

  // Next index modulo n, wrapping from n-1 back to 0.
  function automatic int unsigned rotateInc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_pick.sv
// Combinational round-robin picker: lowest requester at or after ptr, wrapping.
// Uses the double-width trick so the wrap needs no second priority encoder.
module rr_priority_pick #(
  parameter int NR = 4,
  parameter int WI = 2
) (
  input  logic [NR-1:0] req,
  input  logic [WI-1:0] ptr,
  output logic [NR-1:0] gntOnehot,
  output logic [WI-1:0] gntIdx,
  output logic          any
);

  logic [NR-1:0]   mask;
  logic [2*NR-1:0] dbl;
  logic [2*NR-1:0] lowest;

  always_comb begin
    mask = '0;
    for (int k = 0; k < NR; k++) begin
      mask[k] = (k >= int'(ptr));
    end
  end

  // Upper copy holds all requests so anything below ptr is found after the wrap.
  assign dbl       = {req, req & mask};
  assign lowest    = dbl & (-dbl);
  assign gntOnehot = lowest[NR-1:0] | lowest[2*NR-1:NR];
  assign any       = |req;

  always_comb begin
    gntIdx = '0;
    for (int k = 0; k < NR; k++) begin
      if (gntOnehot[k]) begin
        gntIdx = WI'(k);
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin arbiter feeding a single valid/ready output register.
// Define STREAM_ARB_ID_EN to add the oId_BS source-index port and its register.
module stream_rr_arbiter
  import stream_rr_arbiter_pkg::*;
#(
  parameter int WD = 4,
  parameter int NR = 4,
  parameter int WI = `CLOG2(NR)
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [NR-1:0]    iValid_AS,
  output logic [NR-1:0]    oReady_AS,
  input  logic [NR*WD-1:0] iData_AS,
  output logic             oValid_BS,
  input  logic             iReady_BS,
  output logic [WD-1:0]    oData_BS
`ifdef STREAM_ARB_ID_EN
  ,
  output logic [WI-1:0]    oId_BS
`endif
);

  logic          rVld;
  logic [WD-1:0] rData;
  logic [WI-1:0] rPtr;
  logic          slotFree;
  logic          anyReq;
  logic          takeIn;
  logic [NR-1:0] gntOnehot;
  logic [WI-1:0] gntIdx;
  logic [WD-1:0] muxData;

  rr_priority_pick #(
    .NR (NR),
    .WI (WI)
  ) picker (
    .req       (iValid_AS),
    .ptr       (rPtr),
    .gntOnehot (gntOnehot),
    .gntIdx    (gntIdx),
    .any       (anyReq)
  );

  // Ready is held low during reset so no producer sees a phantom handshake.
  assign slotFree  = !rVld || iReady_BS;
  assign takeIn    = slotFree && anyReq && !iRST;
  assign oReady_AS = takeIn ? gntOnehot : '0;

  always_comb begin
    muxData = '0;
    for (int k = 0; k < NR; k++) begin
      if (gntOnehot[k]) begin
        muxData = iData_AS[k*WD +: WD];
      end
    end
  end

  // A drained slot keeps its last data; only the valid flag drops.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rVld  <= 1'b0;
      rData <= '0;
      rPtr  <= '0;
    end else if (takeIn) begin
      rVld  <= 1'b1;
      rData <= muxData;
      rPtr  <= WI'(rotateInc(32'(gntIdx), NR));
    end else if (iReady_BS) begin
      rVld  <= 1'b0;
    end
  end

`ifdef STREAM_ARB_ID_EN
  logic [WI-1:0] rId;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      rId <= '0;
    end else if (takeIn) begin
      rId <= gntIdx;
    end
  end

  assign oId_BS = rId;
`endif

  assign oValid_BS = rVld;
  assign oData_BS  = rData;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter: directed scenarios then random traffic
// against a scan-based round-robin model, a word scoreboard and a fairness bound.
module tb_stream_rr_arbiter;

  localparam int WD = 4;
  localparam int NR = 4;
  localparam int WI = 2;

  logic             iCLK = 1'b0;
  logic             iRST = 1'b1;
  logic [NR-1:0]    iValid_AS = '0;
  logic [NR-1:0]    oReady_AS;
  logic [NR*WD-1:0] iData_AS = '0;
  logic             oValid_BS;
  logic             iReady_BS = 1'b0;
  logic [WD-1:0]    oData_BS;
`ifdef STREAM_ARB_ID_EN
  logic [WI-1:0]    oId_BS;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: one held word plus the round-robin start point.
  bit            mVld;
  logic [WD-1:0] mData;
  int            mPtr;
  int            mId;
  logic [WD-1:0] sbQ[$];
  int            waitCnt[NR];

  stream_rr_arbiter #(
    .WD (WD),
    .NR (NR),
    .WI (WI)
  ) dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iValid_AS (iValid_AS),
    .oReady_AS (oReady_AS),
    .iData_AS  (iData_AS),
    .oValid_BS (oValid_BS),
    .iReady_BS (iReady_BS),
    .oData_BS  (oData_BS)
`ifdef STREAM_ARB_ID_EN
    ,
    .oId_BS    (oId_BS)
`endif
  );

  always #5 iCLK = ~iCLK;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int modelGrant();
    for (int j = 0; j < NR; j++) begin
      if (iValid_AS[(mPtr + j) % NR]) return (mPtr + j) % NR;
    end
    return -1;
  endfunction

  task automatic modelReset();
    mVld  = 1'b0;
    mData = '0;
    mPtr  = 0;
    mId   = 0;
    sbQ.delete();
    for (int k = 0; k < NR; k++) waitCnt[k] = 0;
  endtask

  task automatic applyStimulus(input logic [NR-1:0] valid, input logic [NR*WD-1:0] data,
                               input logic ready);
    iValid_AS = valid;
    iData_AS  = data;
    iReady_BS = ready;
    #1;
  endtask

  // Called on the falling edge; compares against the model, then advances it.
  task automatic checkOutput();
    int            g;
    bit            free;
    bit            accepted;
    logic [NR-1:0] expRdy;
    logic [WD-1:0] wantWord;
    g = modelGrant();
    free = !mVld || iReady_BS;
    expRdy = '0;
    if (free && g >= 0) expRdy[g] = 1'b1;
    compare("valid", 32'(oValid_BS), 32'(mVld));
    compare("ready", 32'(oReady_AS), 32'(expRdy));
    compare("data", 32'(oData_BS), 32'(mData));
`ifdef STREAM_ARB_ID_EN
    compare("id", 32'(oId_BS), 32'(mId));
`endif
    accepted = |(iValid_AS & oReady_AS);
    if (oValid_BS && iReady_BS) begin
      if (sbQ.size() == 0) begin
        compare("sbUnexpectedWord", 32'(oData_BS), 32'hFFFF_FFFF);
      end else begin
        wantWord = sbQ.pop_front();
        compare("sbOrder", 32'(oData_BS), 32'(wantWord));
      end
    end
    for (int k = 0; k < NR; k++) begin
      if (!iValid_AS[k]) begin
        waitCnt[k] = 0;
      end else if (oReady_AS[k]) begin
        sbQ.push_back(iData_AS[k*WD +: WD]);
        compare("fairWait", 32'(waitCnt[k] < NR), 32'd1);
        waitCnt[k] = 0;
      end else if (accepted) begin
        waitCnt[k]++;
      end
    end
    if (free && g >= 0) begin
      mVld  = 1'b1;
      mData = iData_AS[g*WD +: WD];
      mId   = g;
      mPtr  = (g + 1) % NR;
    end else if (mVld && iReady_BS) begin
      mVld = 1'b0;
    end
  endtask

  task automatic step();
    @(negedge iCLK);
    checkOutput();
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    logic [WD-1:0] exp2[5];
    logic [NR-1:0] curValid;
    logic [NR-1:0] toggle;
    exp2 = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    modelReset();

    // Power-on reset with all requesters valid: readies must stay forced low.
    iValid_AS = '1;
    iReady_BS = 1'b1;
    #3;
    compare("rstValid", 32'(oValid_BS), 32'd0);
    compare("rstData", 32'(oData_BS), 32'd0);
    compare("rstReady", 32'(oReady_AS), 32'd0);
    @(posedge iCLK);
    #1;
    iValid_AS = '0;
    #2 iRST = 1'b0;
    @(posedge iCLK);
    #1;

    $display("[TB] reset mid-operation");
    applyStimulus(4'b0001, 16'h000A, 1'b0);
    step();
    step();
    compare("t1Held", 32'(oValid_BS), 32'd1);
    compare("t1HeldData", 32'(oData_BS), 32'hA);
    #2 iRST = 1'b1;
    #1;
    compare("t1AsyncValid", 32'(oValid_BS), 32'd0);
    compare("t1AsyncData", 32'(oData_BS), 32'd0);
    compare("t1AsyncReady", 32'(oReady_AS), 32'd0);
    modelReset();
    iValid_AS = '0;
    #2 iRST = 1'b0;
    @(posedge iCLK);
    #1;

    $display("[TB] all requesters valid");
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    compare("t1FirstGrant", 32'(oReady_AS), 32'b0001);
    for (int i = 0; i < 5; i++) begin
      step();
      compare("t2Data", 32'(oData_BS), 32'(exp2[i]));
`ifdef STREAM_ARB_ID_EN
      compare("t2Id", 32'(oId_BS), 32'(i % NR));
`endif
    end

    $display("[TB] single requester 3");
    applyStimulus(4'b1000, 16'h9321, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      compare("t3Data", 32'(oData_BS), 32'h9);
      compare("t3Ready", 32'(oReady_AS), 32'b1000);
    end

    $display("[TB] backpressure");
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    step();
    applyStimulus(4'b1111, 16'h4321, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      compare("t4StallReady", 32'(oReady_AS), 32'd0);
      compare("t4StallData", 32'(oData_BS), 32'h1);
    end
    applyStimulus(4'b1111, 16'h4321, 1'b1);
    compare("t4ReleaseGrant", 32'(oReady_AS), 32'b0010);
    step();
    compare("t4NextWord", 32'(oData_BS), 32'h2);

    $display("[TB] wrap after requester 2");
    applyStimulus(4'b0100, 16'h4321, 1'b1);
    step();
    compare("t5Word2", 32'(oData_BS), 32'h3);
    applyStimulus(4'b0110, 16'h4321, 1'b1);
    compare("t5WrapGrant", 32'(oReady_AS), 32'b0010);
    step();
    compare("t5Word1", 32'(oData_BS), 32'h2);
    compare("t5NextGrant", 32'(oReady_AS), 32'b0100);
    step();
    compare("t5Word2b", 32'(oData_BS), 32'h3);

    $display("[TB] random traffic");
    curValid = '0;
    for (int i = 0; i < 10000; i++) begin
      toggle = NR'($urandom & $urandom);
      curValid = curValid ^ toggle;
      applyStimulus(curValid, (NR*WD)'($urandom), ($urandom_range(0, 3) != 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
